// File: rtl/pal_pkg.sv
// ============================================================================
// Module      : pal_pkg
// Description : Shared sizing functions, fuse-map offsets and load FSM states
//               for the run-time programmable PAL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pal_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    function automatic int cfg_w(input int n_in, input int n_pt, input int n_out);
        return 2 * n_in * n_pt + n_out * n_pt + 2 * n_out;
    endfunction

    function automatic int or_base(input int n_in, input int n_pt);
        return 2 * n_in * n_pt;
    endfunction

    function automatic int mc_base(input int n_in, input int n_pt, input int n_out);
        return or_base(n_in, n_pt) + n_out * n_pt;
    endfunction

    function automatic int cnt_w(input int cfg_width);
        return $clog2(cfg_width + 1);
    endfunction

    localparam int CFG_W_DEFAULT = cfg_w(4, 10, 4);
    localparam int CNT_W_DEFAULT = $clog2(CFG_W_DEFAULT + 1);

endpackage

`default_nettype wire

// File: rtl/pal_macrocell.sv
// ============================================================================
// Module      : pal_macrocell
// Description : OR of selected product terms, optional inversion, and a
//               combinational/registered output select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pal_macrocell #(
    parameter int N_PT = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_PT-1:0] pt,
    input  logic [N_PT-1:0] or_fuse,
    input  logic            reg_en,
    input  logic            invert,
    output logic            out
);

    logic sum;
    logic mc;
    logic out_d;
    logic out_q;

    assign sum = |(pt & or_fuse);
    assign mc  = sum ^ invert;

    always_comb begin
        out_d = mc;
    end

    // The flop captures every cycle, even while a new map is being shifted in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = reg_en ? out_q : mc;

endmodule

`default_nettype wire

// File: rtl/pal_prog_reg.sv
// ============================================================================
// Module      : pal_prog_reg
// Description : Programmable AND/OR array with macrocells; fuse map shifted
//               into a shadow register and committed atomically.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pal_prog_reg
    import pal_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_PT  = 10,
    parameter int N_OUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic [N_OUT-1:0] out_vec
);

    localparam int CFG_W   = cfg_w(N_IN, N_PT, N_OUT);
    localparam int OR_BASE = or_base(N_IN, N_PT);
    localparam int MC_BASE = mc_base(N_IN, N_PT, N_OUT);
    localparam int CNT_W   = cnt_w(CFG_W);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   active_q, active_d;
    logic               done_q, done_d;
    logic [CFG_W-1:0]   shadow_shift;
    logic [N_PT-1:0]    pt;

    assign shadow_shift = {shadow_q[CFG_W-2:0], cfg_bit};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            ST_LOAD: begin
                // A restart takes priority over a bit presented in the same cycle.
                if (cfg_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid) begin
                    shadow_d = shadow_shift;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CFG_W - 1)) begin
                        active_d = shadow_shift;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign cfg_busy = (state_q == ST_LOAD);
    assign cfg_done = done_q;

    // An unconnected term must read 0, so gate the literal AND with "any fuse set".
    generate
        for (genvar p = 0; p < N_PT; p++) begin : g_pt
            logic [N_IN-1:0] lit_ok;
            for (genvar i = 0; i < N_IN; i++) begin : g_lit
                assign lit_ok[i] = (~active_q[2*N_IN*p + 2*i]     |  in_vec[i]) &
                                   (~active_q[2*N_IN*p + 2*i + 1] | ~in_vec[i]);
            end
            assign pt[p] = (|active_q[2*N_IN*p +: 2*N_IN]) & (&lit_ok);
        end
    endgenerate

    generate
        for (genvar o = 0; o < N_OUT; o++) begin : g_mc
            pal_macrocell #(
                .N_PT (N_PT)
            ) u_mc (
                .clk     (clk),
                .rst_n   (rst_n),
                .pt      (pt),
                .or_fuse (active_q[OR_BASE + o*N_PT +: N_PT]),
                .reg_en  (active_q[MC_BASE + 2*o]),
                .invert  (active_q[MC_BASE + 2*o + 1]),
                .out     (out_vec[o])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pal_prog_reg.sv
// ============================================================================
// Module      : tb_pal_prog_reg
// Description : Directed self-checking bench for pal_prog_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pal_prog_reg;

    localparam int CFG_W = 128;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] in_vec    = 4'b0000;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit   = 1'b0;
    logic       cfg_busy;
    logic       cfg_done;
    logic [3:0] out_vec;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic [CFG_W-1:0] cfg_a, cfg_a_reg, cfg_b, cfg_c;

    pal_prog_reg #(
        .N_IN  (4),
        .N_PT  (10),
        .N_OUT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .out_vec   (out_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cfg_done === 1'b1) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift cfg MSB first; optional stall cycles, aborted prefix, trailing junk bits.
    task automatic load(input logic [CFG_W-1:0] cfg, input bit stall, input int abort_bits,
                        input int extra, input logic [3:0] mid_in, input logic [3:0] mid_exp);
        int d0;
        d0 = done_cnt;
        step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        if (abort_bits > 0) begin
            for (int k = 0; k < abort_bits; k++) begin
                cfg_valid = 1'b1;
                cfg_bit   = 1'b1;
                step();
            end
            cfg_start = 1'b1;
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            step();
            cfg_start = 1'b0;
            chk("abort_busy", {31'd0, cfg_busy}, 32'd1);
            chk("abort_nodone", done_cnt - d0, 32'd0);
        end
        for (int i = CFG_W - 1; i >= 0; i--) begin
            if (stall) begin
                cfg_valid = 1'b0;
                cfg_bit   = 1'($urandom_range(0, 1));
                step();
            end
            if (i == 64) in_vec = mid_in;
            if (i == 62) chk("old_func_mid", {28'd0, out_vec}, {28'd0, mid_exp});
            if (i == 0) begin
                chk("old_func_end", {28'd0, out_vec}, {28'd0, mid_exp});
                chk("pre_busy", {31'd0, cfg_busy}, 32'd1);
                chk("pre_done", {31'd0, cfg_done}, 32'd0);
            end
            cfg_valid = 1'b1;
            cfg_bit   = cfg[i];
            step();
        end
        cfg_valid = (extra > 0);
        cfg_bit   = 1'b1;
        chk("done_pulse", {31'd0, cfg_done}, 32'd1);
        chk("done_busy", {31'd0, cfg_busy}, 32'd0);
        step();
        chk("done_drop", {31'd0, cfg_done}, 32'd0);
        for (int k = 1; k < extra; k++) begin
            cfg_bit = 1'($urandom_range(0, 1));
            step();
        end
        cfg_valid = 1'b0;
        chk("idle_busy", {31'd0, cfg_busy}, 32'd0);
        chk("done_once", done_cnt - d0, 32'd1);
    endtask

    initial begin
        cfg_a = '0;
        cfg_a[0] = 1'b1; cfg_a[2] = 1'b1;       // PT0 = in0 & in1
        cfg_a[12] = 1'b1; cfg_a[14] = 1'b1;     // PT1 = in2 & in3
        cfg_a[80] = 1'b1; cfg_a[81] = 1'b1;     // out0 = PT0 | PT1
        cfg_a_reg = cfg_a;
        cfg_a_reg[120] = 1'b1; cfg_a_reg[121] = 1'b1;
        cfg_c = '0;
        cfg_c[16] = 1'b1; cfg_c[92] = 1'b1;     // out1 = in0 via PT2
        cfg_b = '0;
        cfg_b[27] = 1'b1; cfg_b[103] = 1'b1;    // out2 = ~in1 via PT3

        #3;
        chk("rst_out", {28'd0, out_vec}, 32'd0);
        chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
        #20 rst_n = 1'b1;
        step();

        for (int v = 0; v < 16; v++) begin
            in_vec = 4'(v);
            #1;
            chk("zero_cfg_out", {28'd0, out_vec}, 32'd0);
            step();
        end
        chk("zero_busy", {31'd0, cfg_busy}, 32'd0);
        chk("zero_done", {31'd0, cfg_done}, 32'd0);

        // Config A, combinational
        load(cfg_a, 1'b0, 0, 0, 4'b0011, 4'b0000);
        in_vec = 4'b0011; #1; chk("a_0011", {28'd0, out_vec}, 32'h1);
        in_vec = 4'b1100; #1; chk("a_1100", {28'd0, out_vec}, 32'h1);
        in_vec = 4'b0101; #1; chk("a_0101", {28'd0, out_vec}, 32'h0);
        in_vec = 4'b1111; #1; chk("a_1111", {28'd0, out_vec}, 32'h1);
        in_vec = 4'b1010; #1; chk("a_1010", {28'd0, out_vec}, 32'h0);

        // Config A registered and inverted
        load(cfg_a_reg, 1'b0, 0, 0, 4'b0011, 4'b0001);
        in_vec = 4'b0000;
        step();
        step();
        chk("reg_hold", {28'd0, out_vec}, 32'h1);
        in_vec = 4'b0011;
        #1;
        chk("reg_through_k", {28'd0, out_vec}, 32'h1);
        step();
        chk("reg_after_k1", {28'd0, out_vec}, 32'h0);

        // Config C with stalled loading; old registered function keeps running
        load(cfg_c, 1'b1, 0, 0, 4'b0000, 4'b0001);
        in_vec = 4'b0001; #1; chk("c_0001", {28'd0, out_vec}, 32'h2);
        in_vec = 4'b0000; #1; chk("c_0000", {28'd0, out_vec}, 32'h0);
        in_vec = 4'b1110; #1; chk("c_1110", {28'd0, out_vec}, 32'h0);
        in_vec = 4'b1111; #1; chk("c_1111", {28'd0, out_vec}, 32'h2);

        // Abort after 60 bits, then config B; trailing bits after commit ignored
        load(cfg_b, 1'b0, 60, 5, 4'b0001, 4'b0010);
        in_vec = 4'b0000; #1; chk("b_0000", {28'd0, out_vec}, 32'h4);
        in_vec = 4'b0010; #1; chk("b_0010", {28'd0, out_vec}, 32'h0);
        in_vec = 4'b1101; #1; chk("b_1101", {28'd0, out_vec}, 32'h4);
        in_vec = 4'b0001; #1; chk("b_0001", {28'd0, out_vec}, 32'h4);
        in_vec = 4'b0000;

        // Asynchronous reset in the middle of a load
        step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = cfg_a[CFG_W-1-k];
            step();
        end
        chk("pre_rst_out", {28'd0, out_vec}, 32'h4);
        #2;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("arst_out", {28'd0, out_vec}, 32'h0);
        chk("arst_busy", {31'd0, cfg_busy}, 32'd0);
        chk("arst_done", {31'd0, cfg_done}, 32'd0);
        step();
        rst_n = 1'b1;
        load(cfg_a, 1'b0, 0, 0, 4'b0011, 4'b0000);
        in_vec = 4'b0011; #1; chk("post_rst_0011", {28'd0, out_vec}, 32'h1);
        in_vec = 4'b0101; #1; chk("post_rst_0101", {28'd0, out_vec}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
